// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//   Per-bit debouncer for slide switches. Each line is first brought into the
//   clock domain through a two-flop synchronizer. A private per-bit counter
//   then requires DB_CYCLES consecutive mismatching cycles before the new level
//   is accepted. Registered one-cycle edge pulses are produced per bit, plus a
//   single pulse whenever the gate-select field sw_db[4:2] changes.
//
// Parameters
//   WIDTH      number of switch lines (bits 1:0 gate operands, 4:2 gate select)
//   DB_CYCLES  consecutive stable cycles needed to accept a level (>= 2)
//
// Ports
//   clk         system clock, rising-edge active
//   rst_n       asynchronous active-low reset
//   sw_raw      raw bouncing switch levels (asynchronous)
//   sw_db       debounced, registered levels
//   sw_rise     one-cycle pulse per bit on an accepted 0->1 transition
//   sw_fall     one-cycle pulse per bit on an accepted 1->0 transition
//   sel_change  one-cycle pulse when sw_db[4:2] changes (0 when WIDTH < 5)
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int WIDTH     = 5,
  parameter int DB_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             sel_change
);

  // Counter only has to reach DB_CYCLES-1, so clog2 bits suffice; keep >= 1 bit.
  localparam int CW = ($clog2(DB_CYCLES) < 1) ? 1 : $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] sw_db_q;
  logic [WIDTH-1:0] sw_db_d;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_q;
  logic [WIDTH-1:0] fall_d;
  logic             sel_q;
  logic             sel_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];

  // Per-bit debounce decision: clear on agreement, count on mismatch,
  // accept and clear once the mismatch has lasted DB_CYCLES cycles.
  always_comb begin
    sw_db_d = sw_db_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync2_q[i] == sw_db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        cnt_d[i]   = '0;
        sw_db_d[i] = sync2_q[i];
        // Pulses are registered alongside sw_db so they line up with the new level.
        rise_d[i]  = sync2_q[i];
        fall_d[i]  = ~sync2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Select-change pulse only exists when the select field is present.
  generate
    if (WIDTH >= 5) begin : g_sel
      assign sel_d = |(rise_d[4:2] | fall_d[4:2]);
    end else begin : g_no_sel
      assign sel_d = 1'b0;
    end
  endgenerate

  // All state: synchronizer, debounced level, counters and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sw_db_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      sel_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= sw_raw;
      sync2_q <= sync1_q;
      sw_db_q <= sw_db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      sel_q   <= sel_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign sw_db      = sw_db_q;
  assign sw_rise    = rise_q;
  assign sw_fall    = fall_q;
  assign sel_change = sel_q;

endmodule
